// File: rtl/alu_share_ctrl_pkg.sv
// ============================================================================
// Module      : alu_share_ctrl_pkg
// Description : Shared ALU op codes, boolean constants and sharing-FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_MUL  = 5'd2;
    localparam logic [4:0] ALU_JAL  = 5'd3;
    localparam logic [4:0] ALU_BEQ  = 5'd4;
    localparam logic [4:0] ALU_BNE  = 5'd5;
    localparam logic [4:0] ALU_BLT  = 5'd6;
    localparam logic [4:0] ALU_BGE  = 5'd7;
    localparam logic [4:0] ALU_BLTU = 5'd8;
    localparam logic [4:0] ALU_BGEU = 5'd9;

    typedef enum logic [1:0] {
        ALU_SHARE_IDLE = 2'd0,
        ALU_SHARE_EXEC = 2'd1,
        ALU_SHARE_DONE = 2'd2
    } alu_share_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
// ============================================================================
// Module      : alu_share_ctrl_if
// Description : Two issue request ports plus one tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_share_ctrl_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [4:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [4:0]  req1_op;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_branch_en;

    // Requesters and response consumer
    modport master (
        output req0_valid, req0_src1, req0_src2, req0_op,
        output req1_valid, req1_src1, req1_src2, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_branch_en
    );

    // Sharing controller
    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_op,
        input  req1_valid, req1_src1, req1_src2, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_branch_en
    );

endinterface

`default_nettype wire

// File: rtl/alu_share_ctrl_alu_stage.sv
// ============================================================================
// Module      : alu_share_ctrl_alu_stage
// Description : Shared integer datapath: ADD/SUB/MUL and branch compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_ctrl_alu_stage
    import alu_share_ctrl_pkg::*;
(
    input  wire logic [31:0] i_src1,
    input  wire logic [31:0] i_src2,
    input  wire logic [4:0]  i_op,
    output logic      [31:0] o_result,
    output logic             o_branch_en
);

    always_comb begin
        o_result    = 32'h0;
        o_branch_en = FALSE;
        case (i_op)
            ALU_ADD:  o_result    = i_src1 + i_src2;
            ALU_SUB:  o_result    = i_src1 - i_src2;
            ALU_MUL:  o_result    = i_src1 * i_src2;
            ALU_JAL:  o_branch_en = TRUE;
            ALU_BEQ:  o_branch_en = (i_src1 == i_src2);
            ALU_BNE:  o_branch_en = (i_src1 != i_src2);
            ALU_BLT:  o_branch_en = ($signed(i_src1) <  $signed(i_src2));
            ALU_BGE:  o_branch_en = ($signed(i_src1) >= $signed(i_src2));
            ALU_BLTU: o_branch_en = (i_src1 <  i_src2);
            ALU_BGEU: o_branch_en = (i_src1 >= i_src2);
            default:  o_branch_en = FALSE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ============================================================================
// Module      : alu_share_ctrl
// Description : Arbitrates two issue requesters onto one shared ALU stage and
//               returns a tagged result. ALU_SHARE_RR_EN selects round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_share_ctrl_if.slave  bus
);

    localparam logic       c_mul_multi = (MUL_CYCLES > 1);
    localparam logic [3:0] c_mul_load  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    alu_share_state_t r_state;
    alu_share_state_t w_state_nxt;

    logic [3:0]  r_cnt;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [4:0]  r_op;
    logic        r_id;

    logic        w_prefer1;
    logic        w_grant1;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [4:0]  w_req_op;
    logic [31:0] w_dp_result;
    logic        w_dp_branch;

`ifdef ALU_SHARE_RR_EN
    logic r_last_grant;

    // Reset value 1 lets req0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            r_last_grant <= 1'b1;
        else if (w_accept)
            r_last_grant <= w_grant1;
    end

    assign w_prefer1 = ~r_last_grant;
`else
    assign w_prefer1 = 1'b0;
`endif

    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | w_prefer1);
    assign w_req_op = w_grant1 ? bus.req1_op : bus.req0_op;

    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = FALSE;
        w_ready1    = FALSE;
        case (r_state)
            ALU_SHARE_IDLE: begin
                // Gated by rst so no handshake is advertised that the edge would drop.
                w_ready0 = ~rst & bus.req0_valid & ~w_grant1;
                w_ready1 = ~rst & w_grant1;
                if (w_ready0 | w_ready1) begin
                    if ((w_req_op == ALU_MUL) && c_mul_multi)
                        w_state_nxt = ALU_SHARE_EXEC;
                    else
                        w_state_nxt = ALU_SHARE_DONE;
                end
            end
            ALU_SHARE_EXEC: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = ALU_SHARE_DONE;
            end
            ALU_SHARE_DONE: begin
                if (bus.resp_ready)
                    w_state_nxt = ALU_SHARE_IDLE;
            end
            default: w_state_nxt = ALU_SHARE_IDLE;
        endcase
    end

    assign w_accept = w_ready0 | w_ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ALU_SHARE_IDLE;
            r_cnt   <= 4'd0;
            r_src1  <= 32'h0;
            r_src2  <= 32'h0;
            r_op    <= ALU_ADD;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_src1 <= w_grant1 ? bus.req1_src1 : bus.req0_src1;
                r_src2 <= w_grant1 ? bus.req1_src2 : bus.req0_src2;
                r_op   <= w_req_op;
                r_id   <= w_grant1;
                r_cnt  <= c_mul_load;
            end else if ((r_state == ALU_SHARE_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Datapath sees only the latched operands, which hold steady through DONE,
    // so the response fields are stable for as long as resp_valid is high.
    alu_share_ctrl_alu_stage u_alu_stage (
        .i_src1      (r_src1),
        .i_src2      (r_src2),
        .i_op        (r_op),
        .o_result    (w_dp_result),
        .o_branch_en (w_dp_branch)
    );

    assign bus.req0_ready     = w_ready0;
    assign bus.req1_ready     = w_ready1;
    assign bus.resp_valid     = (r_state == ALU_SHARE_DONE);
    assign bus.resp_id        = r_id;
    assign bus.resp_result    = w_dp_result;
    assign bus.resp_branch_en = w_dp_branch;

endmodule

`default_nettype wire
